// File: rtl/ram_delay_ctrl.sv
// ram_delay_ctrl
//  Sequences a dual-port RAM (both ports on clk) as a programmable sample
//  delay line. It owns the write/read pointer, the delay-length
//  reconfiguration handshake, priming and output qualification.
//
//  Optional feature macro: RAM_DELAY_CTRL_FLUSH_EN
//   When it is defined, the RAM is zero-filled after every reconfiguration
//   and after reset. The controller then goes straight to RUN, so the first
//   len outputs are valid zeros. When it is undefined, stale RAM contents are
//   hidden only by q_valid=0 while priming.
//
//  Ports
//   clk, rst_n        single clock, synchronous active-low reset
//   wr, d             sample strobe and sample
//   cfg_req, cfg_len  delay-change request (level) and requested length
//   cfg_ack           1-cycle pulse when the new length is in effect
//   busy              high while reconfiguring or flushing; wr is dropped
//   drop              registered pulse, one cycle after a discarded wr
//   ram_raddr         RAM port B address (1-cycle synchronous read -> ram_rdata)
//   ram_we/ram_waddr/ram_wdata  RAM port A write
//   q, q_stb, q_valid delayed sample, update strobe, true-sample qualifier
module ram_delay_ctrl #(
    parameter int P_NBITS_ADDR  = 8,
    parameter int P_NBITS_DATA  = 14,
    parameter int P_DEFAULT_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [P_NBITS_DATA-1:0] d,
    input  logic                    cfg_req,
    input  logic [P_NBITS_ADDR-1:0] cfg_len,
    output logic                    cfg_ack,
    output logic                    busy,
    output logic                    drop,
    output logic [P_NBITS_ADDR-1:0] ram_raddr,
    input  logic [P_NBITS_DATA-1:0] ram_rdata,
    output logic                    ram_we,
    output logic [P_NBITS_ADDR-1:0] ram_waddr,
    output logic [P_NBITS_DATA-1:0] ram_wdata,
    output logic [P_NBITS_DATA-1:0] q,
    output logic                    q_stb,
    output logic                    q_valid
);
    localparam int AW = P_NBITS_ADDR;
    localparam logic [AW-1:0] LEN_RST = AW'(P_DEFAULT_LEN);
    localparam logic [AW-1:0] LEN_MIN = AW'(2);
    localparam logic [AW-1:0] ONE     = AW'(1);

    typedef enum logic [1:0] {
        ST_PRIME  = 2'd0,
        ST_RUN    = 2'd1,
        ST_RECONF = 2'd2
`ifdef RAM_DELAY_CTRL_FLUSH_EN
        , ST_FLUSH = 2'd3
`endif
    } state_t;

    // A delay shorter than 2 would make the read and the write of one slot
    // meet on the same edge, so short requests are raised to 2.
    function automatic logic [AW-1:0] clamp_len(input logic [AW-1:0] l);
        return (l < LEN_MIN) ? LEN_MIN : l;
    endfunction

    state_t          state, state_nxt;
    logic [AW-1:0]   len, len_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [AW-1:0]   prime_cnt, prime_nxt;
    logic [1:0]      drain_cnt, drain_nxt;
    logic            ack_nxt;
    logic            accept;
    logic            flush_we;
    logic            is_busy;
    logic            busy_nxt;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
    logic [AW-1:0]   flush_cnt, flush_nxt;
`endif

    // Pipeline stage 1 (read issued); ram_raddr doubles as this stage's pointer.
    logic                    s1_vld;
    logic                    s1_qv;
    logic [P_NBITS_DATA-1:0] s1_d;
    // Pipeline stage 2 (write issued, read data returning).
    logic                    s2_vld;
    logic                    s2_qv;

    // Decodes the current state into the busy flag.
    always_comb begin
`ifdef RAM_DELAY_CTRL_FLUSH_EN
        is_busy  = (state == ST_RECONF) || (state == ST_FLUSH);
        busy_nxt = (state_nxt == ST_RECONF) || (state_nxt == ST_FLUSH);
`else
        is_busy  = (state == ST_RECONF);
        busy_nxt = (state_nxt == ST_RECONF);
`endif
    end

    // Next-state, pointer and length logic.
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        ptr_nxt   = ptr;
        prime_nxt = prime_cnt;
        drain_nxt = drain_cnt;
        ack_nxt   = 1'b0;
        accept    = 1'b0;
        flush_we  = 1'b0;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
        flush_nxt = flush_cnt;
`endif
        case (state)
            ST_PRIME: begin
                accept = wr;
                if (wr && (prime_cnt == len - ONE)) begin
                    prime_nxt = '0;
                    state_nxt = ST_RUN;
                end else if (wr) begin
                    prime_nxt = prime_cnt + ONE;
                end else begin
                    prime_nxt = prime_cnt;
                end
                // A simultaneous wr is still taken above under the old length.
                if (cfg_req) begin
                    state_nxt = ST_RECONF;
                    len_nxt   = clamp_len(cfg_len);
                    drain_nxt = 2'd0;
                end else begin
                    len_nxt = len;
                end
            end
            ST_RUN: begin
                accept = wr;
                if (cfg_req) begin
                    state_nxt = ST_RECONF;
                    len_nxt   = clamp_len(cfg_len);
                    drain_nxt = 2'd0;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RECONF: begin
                // Three cycles let any accepted sample leave the pipeline.
                if (drain_cnt == 2'd2) begin
                    prime_nxt = '0;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
                    state_nxt = ST_FLUSH;
                    flush_nxt = '0;
`else
                    state_nxt = ST_PRIME;
                    ack_nxt   = 1'b1;
`endif
                end else begin
                    drain_nxt = drain_cnt + 2'd1;
                end
            end
`ifdef RAM_DELAY_CTRL_FLUSH_EN
            ST_FLUSH: begin
                flush_we = 1'b1;
                if (flush_cnt == len - ONE) begin
                    state_nxt = ST_RUN;
                    ack_nxt   = 1'b1;
                end else begin
                    flush_nxt = flush_cnt + ONE;
                end
            end
`endif
            default: begin
                state_nxt = ST_PRIME;
            end
        endcase
        if (accept) begin
            ptr_nxt = (ptr == len - ONE) ? '0 : ptr + ONE;
        end else if (ack_nxt || (state == ST_RECONF)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = ptr;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len       <= LEN_RST;
            ptr       <= '0;
            prime_cnt <= '0;
            drain_cnt <= 2'd0;
            cfg_ack   <= 1'b0;
            drop      <= 1'b0;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            busy      <= 1'b1;
`else
            state     <= ST_PRIME;
            busy      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            ptr       <= ptr_nxt;
            prime_cnt <= prime_nxt;
            drain_cnt <= drain_nxt;
            cfg_ack   <= ack_nxt;
            busy      <= busy_nxt;
            drop      <= wr && is_busy;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
            flush_cnt <= flush_nxt;
`endif
        end
    end

    // Sample pipeline: read the old slot, then overwrite it, then present q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_qv     <= 1'b0;
            s1_d      <= '0;
            ram_raddr <= '0;
            s2_vld    <= 1'b0;
            s2_qv     <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            q         <= '0;
            q_stb     <= 1'b0;
            q_valid   <= 1'b0;
        end else begin
            s1_vld <= accept;
            s1_qv  <= (state == ST_RUN);
            if (accept) begin
                ram_raddr <= ptr;
                s1_d      <= d;
            end else begin
                ram_raddr <= ram_raddr;
                s1_d      <= s1_d;
            end
            s2_vld    <= s1_vld;
            s2_qv     <= s1_qv;
            ram_we    <= s1_vld || flush_we;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
            ram_waddr <= flush_we ? flush_cnt : ram_raddr;
`else
            ram_waddr <= ram_raddr;
`endif
            ram_wdata <= flush_we ? '0 : s1_d;
            q_stb     <= s2_vld;
            q_valid   <= s2_vld && s2_qv;
            if (s2_vld) begin
                q <= ram_rdata;
            end else begin
                q <= q;
            end
        end
    end
endmodule

// File: tb/tb_ram_delay_ctrl.sv
// Bench for ram_delay_ctrl: behavioural RAM plus a sample-history model of
// the delay line. Expected outputs are derived from the accepted-sample list.
module tb_ram_delay_ctrl;
    localparam int AW = 8;
    localparam int DW = 14;
`ifdef RAM_DELAY_CTRL_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] d = '0;
    logic          cfg_req = 1'b0;
    logic [AW-1:0] cfg_len = '0;
    logic          cfg_ack, busy, drop, ram_we, q_stb, q_valid;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DW-1:0] ram_rdata, ram_wdata, q;
    logic [DW-1:0] mem [0:255];

    ram_delay_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .d(d), .cfg_req(cfg_req), .cfg_len(cfg_len),
        .cfg_ack(cfg_ack), .busy(busy), .drop(drop), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .q(q), .q_stb(q_stb), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= DW'($urandom);
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        bit            vl;
    } ev_t;

    ev_t           oq[$];
    ev_t           wq[$];
    logic [DW-1:0] hist[$];
    int            cyc = 0;
    int            mbusy = 0;
    int            mlen = 16;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            e_drop, e_ack;
    logic [41:0]   obs, exp_v;

    task automatic sched_flush(input int start);
        ev_t e;
        for (int j = 0; j < mlen; j++) begin
            e.c = start + j; e.a = AW'(j); e.v = '0; e.vl = 1'b1;
            wq.push_back(e);
        end
    endtask

    // Drive one cycle, advance the model, and build observed/expected vectors.
    task automatic drive(input bit i_wr, input logic [DW-1:0] i_d, input bit i_req,
                         input logic [AW-1:0] i_len);
        int  idx;
        ev_t e, oe, we_e;
        bit  e_stb, e_we;
        wr = i_wr; d = i_d; cfg_req = i_req; cfg_len = i_len;
        @(posedge clk);
        e_drop = 1'b0; e_ack = 1'b0;
        if (mbusy == 0) begin
            if (i_wr) begin
                idx = hist.size();
                e.c = cyc + 3; e.a = '0;
                if (idx < mlen) begin e.v = '0; e.vl = FL; end
                else begin e.v = hist[idx - mlen]; e.vl = 1'b1; end
                oq.push_back(e);
                e.c = cyc + 2; e.a = AW'(idx % mlen); e.v = i_d; e.vl = 1'b1;
                wq.push_back(e);
                hist.push_back(i_d);
            end
            if (i_req) begin
                mlen = (int'(i_len) < 2) ? 2 : int'(i_len);
                hist.delete();
                mbusy = FL ? 3 + mlen : 3;
                if (FL) sched_flush(cyc + 5);
            end
        end else begin
            e_drop = i_wr;
            mbusy--;
            e_ack = (mbusy == 0);
        end
        cyc++;
        #1;
        e_stb = 1'b0; e_we = 1'b0;
        oe.c = 0; oe.a = '0; oe.v = '0; oe.vl = 1'b0;
        we_e = oe;
        if (oq.size() > 0 && oq[0].c == cyc) begin oe = oq.pop_front(); e_stb = 1'b1; end
        if (wq.size() > 0 && wq[0].c == cyc) begin we_e = wq.pop_front(); e_we = 1'b1; end
        exp_v = {e_stb, e_stb & oe.vl, e_drop, mbusy > 0, e_ack, e_we,
                 (e_stb & oe.vl) ? oe.v : 14'h0, e_we ? we_e.a : 8'h0, e_we ? we_e.v : 14'h0};
        obs   = {q_stb, q_valid, drop, busy, cfg_ack, ram_we,
                 (e_stb & oe.vl) ? q : 14'h0, e_we ? ram_waddr : 8'h0, e_we ? ram_wdata : 14'h0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr = 1'b0; cfg_req = 1'b0;
        @(posedge clk);
        cyc++;
        oq.delete(); wq.delete(); hist.delete();
        mlen = 16;
        mbusy = FL ? 16 : 0;
        if (FL) sched_flush(cyc + 1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({q_stb, q_valid, drop, cfg_ack, ram_we, busy, q, ram_raddr, ram_waddr, ram_wdata} !==
            {5'b0, FL, 14'h0, 8'h0, 8'h0, 14'h0}) begin
            n_fail++;
            $display("FAIL reset got=%b %h %h %h %h", {q_stb, q_valid, drop, cfg_ack, ram_we, busy},
                     q, ram_raddr, ram_waddr, ram_wdata);
        end
    endtask

    task automatic test_stream();
        for (int n = 0; n < 54; n++) begin
            drive(n < 50, DW'(n), 1'b0, 8'd0);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_sparse();
        bit req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            drive((n % 3) == 0, DW'($urandom), req, 8'd4);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sparse cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (e_ack) req = 1'b0;
        end
    endtask

    task automatic test_reconf();
        bit hold = 1'b0;
        bit w;
        for (int n = 0; n < 50; n++) begin
            w = (n == 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(w, DW'($urandom), (n == 20) || hold, 8'd5);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reconf cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (n == 20) hold = 1'b1;
            if (e_ack) hold = 1'b0;
        end
    endtask

    task automatic test_clamp();
        logic [AW-1:0] lens[3];
        bit req, lag;
        lens[0] = 8'd1; lens[1] = 8'd0; lens[2] = 8'd2;
        lag = 1'b0;
        for (int p = 0; p < 3; p++) begin
            req = 1'b1;
            for (int n = 0; n < 20; n++) begin
                drive(1'b1, DW'($urandom), req, lens[p]);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL clamp p=%0d cyc=%0d got=%h exp=%h", p, cyc, obs, exp_v);
                end
                // In the last phase the request is held one cycle past the
                // ack, which starts a second reconfiguration.
                if (e_ack) begin
                    if (p == 2 && !lag) lag = 1'b1;
                    else req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_midreset();
        for (int n = 0; n < 12; n++) begin
            drive(1'b1, DW'($urandom), 1'b0, 8'd0);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL prereset cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        do_reset();
        n_tests++;
        if ({q_stb, q_valid, drop, cfg_ack, ram_we, busy, q} !== {5'b0, FL, 14'h0}) begin
            n_fail++;
            $display("FAIL midreset got=%b q=%h", {q_stb, q_valid, drop, cfg_ack, ram_we, busy}, q);
        end
        for (int n = 0; n < 50; n++) begin
            drive(1'b1, DW'($urandom), 1'b0, 8'd0);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL postreset cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
    endtask

`ifdef RAM_DELAY_CTRL_FLUSH_EN
    task automatic test_flush();
        bit req = 1'b1;
        for (int n = 0; n < 40; n++) begin
            drive(1'b1, DW'($urandom), req, 8'd8);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL flush cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (e_ack) req = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_sparse();
        test_reconf();
        test_clamp();
        test_midreset();
`ifdef RAM_DELAY_CTRL_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
